// File: rtl/sm_core_dispatcher.sv
// Launch-side dispatcher: starts, holds and releases N control units through 2-bit status lanes,
// then reports which cores finished, whether the launch timed out, and how many RUN cycles it used.
`timescale 1ns/1ps
module sm_core_dispatcher #(
  parameter int N_CORES = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 launch,
  input  logic [N_CORES-1:0]   launch_mask,
  input  logic [CNT_W-1:0]     timeout_limit,
  input  logic [N_CORES-1:0]   end_process,
  output logic [2*N_CORES-1:0] status,
  output logic                 busy,
  output logic                 done,
  output logic [N_CORES-1:0]   done_mask,
  output logic                 timed_out,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [2:0]           dbg_state
);

  // Handshake: launch is a one-cycle request taken only in IDLE with a non-empty mask (busy=0);
  // there is no back-pressure, requests while busy are dropped, and done is a one-cycle pulse.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_RUN     = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t                 state_q, state_d;
  logic [N_CORES-1:0]     act_q, act_d;
  logic [N_CORES-1:0]     fin_q, fin_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   to_q, to_d;
  logic [N_CORES-1:0]     dmask_q, dmask_d;
  logic [CNT_W-1:0]       ccount_q, ccount_d;
  logic [2*N_CORES-1:0]   status_q, status_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       cnt_p1;
  logic [1:0]             lane_code;

  assign cnt_p1 = cnt_q + CNT_ONE;

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    fin_d    = fin_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    dmask_d  = dmask_q;
    ccount_d = ccount_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (launch && (launch_mask != '0)) begin
          act_d   = launch_mask;
          fin_d   = '0;
          cnt_d   = '0;
          to_d    = 1'b0;
          dmask_d = '0;
          state_d = S_START;
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        fin_d = fin_q | (end_process & act_q);
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_p1;
        // Completion is tested first so a tie with the timeout is not flagged as a timeout.
        if (fin_d == act_q) begin
          state_d = S_RELEASE;
        end else if ((timeout_limit != '0) && (cnt_p1 == timeout_limit)) begin
          state_d = S_RELEASE;
          to_d    = 1'b1;
        end
      end
      S_RELEASE: begin
        state_d  = S_DONE;
        done_d   = 1'b1;
        dmask_d  = fin_q;
        ccount_d = cnt_q;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are precomputed from the next state so every lane changes exactly at a clock edge.
    unique case (state_d)
      S_START:   lane_code = 2'b01;
      S_RUN:     lane_code = 2'b10;
      S_RELEASE: lane_code = 2'b11;
      default:   lane_code = 2'b00;
    endcase
    status_d = '0;
    for (int i = 0; i < N_CORES; i++) begin
      status_d[2*i +: 2] = act_d[i] ? lane_code : 2'b00;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      act_q    <= '0;
      fin_q    <= '0;
      cnt_q    <= '0;
      to_q     <= 1'b0;
      dmask_q  <= '0;
      ccount_q <= '0;
      status_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      fin_q    <= fin_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      dmask_q  <= dmask_d;
      ccount_q <= ccount_d;
      status_q <= status_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign status      = status_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign done_mask   = dmask_q;
  assign timed_out   = to_q;
  assign cycle_count = ccount_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sm_core_dispatcher.sv
// Bench for sm_core_dispatcher: directed scenarios plus randomized launches, each launch's outcome
// predicted from per-core finish times (run length = min of completion time and timeout).
`timescale 1ns/1ps
module tb_sm_core_dispatcher;
  localparam int N     = 4;
  localparam int CW    = 16;
  localparam int W     = N + 1 + CW;
  localparam int NEVER = 1000;

  logic           clock = 1'b0;
  logic           reset;
  logic           launch;
  logic [N-1:0]   launch_mask;
  logic [CW-1:0]  timeout_limit;
  logic [N-1:0]   end_process;
  logic [2*N-1:0] status;
  logic           busy;
  logic           done;
  logic [N-1:0]   done_mask;
  logic           timed_out;
  logic [CW-1:0]  cycle_count;
  logic [2:0]     dbg_state;

  sm_core_dispatcher #(.N_CORES(N), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .launch(launch), .launch_mask(launch_mask),
    .timeout_limit(timeout_limit), .end_process(end_process), .status(status),
    .busy(busy), .done(done), .done_mask(done_mask), .timed_out(timed_out),
    .cycle_count(cycle_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [W-1:0]  exp_q[$];
  int            ft[N];
  logic [N-1:0]  last_dm;
  logic          last_to;
  logic [CW-1:0] last_cc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2*N-1:0] lanes(input logic [N-1:0] mask, input logic [1:0] code);
    logic [2*N-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) if (mask[i]) s[2*i +: 2] = code;
    return s;
  endfunction

  // driver + reference model: one launch with finish times in ft[] (offset from START cycle)
  task automatic run_launch(input logic [N-1:0] mask, input int limit, input bit dup);
    int             c, r, eff;
    bit             to;
    logic [N-1:0]   dm, ep;
    logic [W-1:0]   rec;
    logic [1:0]     code;
    c = 0;
    for (int i = 0; i < N; i++) if (mask[i]) begin
      eff = (ft[i] < 1) ? 1 : ft[i];
      if (eff > c) c = eff;
    end
    if (limit != 0 && limit < c) begin r = limit; to = 1'b1; end
    else begin r = c; to = 1'b0; end
    dm = '0;
    for (int i = 0; i < N; i++) if (mask[i] && (((ft[i] < 1) ? 1 : ft[i]) <= r)) dm[i] = 1'b1;
    exp_q.push_back({dm, to, CW'(r)});

    launch = 1'b1; launch_mask = mask; timeout_limit = CW'(limit);
    tick();
    for (int k = 0; k <= r + 2; k++) begin
      ep = N'($urandom) & ~mask;
      for (int i = 0; i < N; i++) if (mask[i] && ft[i] <= k) ep[i] = 1'b1;
      end_process = ep;
      launch = 1'b0;
      launch_mask = N'($urandom_range(1, (1 << N) - 1));
      if (dup && (k == 2 || k == r + 2)) launch = 1'b1;
      code = (k == 0) ? 2'b01 : (k <= r) ? 2'b10 : (k == r + 1) ? 2'b11 : 2'b00;
      check_eq("status", status, lanes(mask, code));
      check_eq("busy", busy, 1'b1);
      check_eq("done", done, (k == r + 2));
      if (k == r + 2) begin
        rec = exp_q.pop_front();
        check_eq("done_mask", done_mask, rec[W-1 -: N]);
        check_eq("timed_out", timed_out, rec[CW]);
        check_eq("cycle_count", cycle_count, rec[CW-1:0]);
        last_dm = rec[W-1 -: N]; last_to = rec[CW]; last_cc = rec[CW-1:0];
      end
      tick();
    end
    launch = 1'b0; end_process = '0;
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_done", done, 1'b0);
    check_eq("idle_status", status, '0);
    check_eq("hold_cycle_count", cycle_count, last_cc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] m;
    int           lim;
    reset = 1'b1; launch = 1'b0; launch_mask = '0; timeout_limit = '0; end_process = '0;
    last_dm = '0; last_to = 1'b0; last_cc = '0;
    repeat (3) tick();
    reset = 1'b0;
    check_eq("rst_status", status, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_done_mask", done_mask, '0);
    check_eq("rst_timed_out", timed_out, 1'b0);
    check_eq("rst_cycle_count", cycle_count, '0);
    tick();

    // basic launch on cores 0 and 2
    ft = '{5, NEVER, 8, NEVER};
    run_launch(4'b0101, 0, 1'b0);

    // empty-mask launch is ignored
    launch = 1'b1; launch_mask = '0; timeout_limit = CW'(3);
    tick();
    launch = 1'b0;
    check_eq("mask0_busy", busy, 1'b0);
    check_eq("mask0_status", status, '0);
    check_eq("mask0_done_mask", done_mask, last_dm);
    check_eq("mask0_cycle_count", cycle_count, last_cc);
    tick();
    check_eq("mask0_busy2", busy, 1'b0);

    // timeout with only core 3 finishing
    ft = '{NEVER, NEVER, NEVER, 4};
    run_launch(4'b1111, 10, 1'b0);
    // final finish coincides with the timeout cycle
    ft = '{3, 7, 10, 10};
    run_launch(4'b1111, 10, 1'b0);
    // finish already high at START, extra launches during RUN and DONE
    ft = '{0, 0, 0, 0};
    run_launch(4'b0110, 5, 1'b1);
    // accepted immediately after the done cycle
    ft = '{2, 0, 6, 3};
    run_launch(4'b1011, 0, 1'b1);

    for (int n = 0; n < 25; n++) begin
      lim = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20));
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        ft[i] = (lim != 0 && $urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, 25));
      run_launch(m, lim, 1'($urandom_range(0, 1)));
    end

    // reset in the middle of RUN
    launch = 1'b1; launch_mask = 4'b1111; timeout_limit = '0;
    tick();
    launch = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check_eq("pre_rst_status", status, lanes(4'b1111, 2'b10));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_status", status, '0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_done", done, 1'b0);
    check_eq("mid_rst_done_mask", done_mask, '0);
    check_eq("mid_rst_cycle_count", cycle_count, '0);
    for (int k = 0; k < 5; k++) begin
      end_process = N'($urandom);
      tick();
      check_eq("post_rst_done", done, 1'b0);
      check_eq("post_rst_busy", busy, 1'b0);
    end
    end_process = '0;
    last_cc = '0;
    ft = '{1, 4, NEVER, 2};
    run_launch(4'b1011, 0, 1'b0);

    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
